// File: rtl/seg7_card_decoder.sv
// Seven-segment baccarat card decoder: debounces segment beats per slot, commits stable cards and keeps hand totals.
// Optional feature: define SEG7_ERR_COUNT_EN to build the saturating err_count counter (otherwise err_count is tied to 0).
module seg7_card_decoder #(
    parameter int STABLE_N = 2
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       clr,
    input  logic       seg_valid,
    output logic       seg_ready,
    input  logic [2:0] seg_digit,
    input  logic [6:0] seg_pattern,
    output logic       card_valid,
    output logic [2:0] card_slot,
    output logic [3:0] card_value,
    output logic       card_err,
    output logic [3:0] player_score,
    output logic [3:0] dealer_score,
    output logic [7:0] err_count
);

    localparam int         NUM_SLOTS  = 6;
    localparam logic [2:0] STABLE_CNT = 3'(STABLE_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCORE  = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } dec_t;

    state_t     state_q;
    logic       seg_ready_q;
    logic [2:0] beat_digit_q;
    logic [6:0] beat_pat_q;
    logic [6:0] cand_pat_q [NUM_SLOTS];
    logic [2:0] cand_cnt_q [NUM_SLOTS];
    logic [3:0] slot_q     [NUM_SLOTS];
    logic       card_valid_q;
    logic       card_err_q;
    logic [2:0] card_slot_q;
    logic [3:0] card_value_q;
    logic [3:0] player_q;
    logic [3:0] dealer_q;

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d.legal = 1'b1;
        case (pat)
            7'b1111111: d.value = 4'd0;
            7'b0001000: d.value = 4'd1;
            7'b0100100: d.value = 4'd2;
            7'b0110000: d.value = 4'd3;
            7'b0011001: d.value = 4'd4;
            7'b0010010: d.value = 4'd5;
            7'b0000010: d.value = 4'd6;
            7'b1111000: d.value = 4'd7;
            7'b0000000: d.value = 4'd8;
            7'b0010000: d.value = 4'd9;
            7'b1000000: d.value = 4'd10;
            7'b1100001: d.value = 4'd11;
            7'b0011000: d.value = 4'd12;
            7'b0001001: d.value = 4'd13;
            default: begin
                d.legal = 1'b0;
                d.value = 4'd0;
            end
        endcase
        return d;
    endfunction

    // Blank and court cards score nothing in baccarat.
    function automatic logic [4:0] points(input logic [3:0] v);
        return (v >= 4'd1 && v <= 4'd9) ? {1'b0, v} : 5'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20)      r = s - 5'd20;
        else if (s >= 5'd10) r = s - 5'd10;
        else                 r = s;
        return r[3:0];
    endfunction

    dec_t       dec;
    logic       slot_ok;
    logic       beat_ok;
    logic [2:0] slot_idx;
    logic       same_pat;
    logic [2:0] cnt_next;
    logic       commit;
    logic       value_changed;
    logic [4:0] player_sum;
    logic [4:0] dealer_sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec           = decode(beat_pat_q);
        slot_ok       = (beat_digit_q < 3'(NUM_SLOTS));
        beat_ok       = slot_ok && dec.legal;
        slot_idx      = slot_ok ? beat_digit_q : 3'd0;
        same_pat      = 1'b0;
        cnt_next      = 3'd1;
        commit        = 1'b0;
        value_changed = 1'b0;
        if (cand_cnt_q[slot_idx] != 3'd0 && cand_pat_q[slot_idx] == beat_pat_q) begin
            same_pat = 1'b1;
        end
        if (same_pat) begin
            cnt_next = (cand_cnt_q[slot_idx] >= STABLE_CNT) ? STABLE_CNT
                                                             : cand_cnt_q[slot_idx] + 3'd1;
        end
        if (beat_ok && cnt_next == STABLE_CNT) begin
            commit        = 1'b1;
            value_changed = (dec.value != slot_q[slot_idx]);
        end
        player_sum = points(slot_q[0]) + points(slot_q[1]) + points(slot_q[2]);
        dealer_sum = points(slot_q[3]) + points(slot_q[4]) + points(slot_q[5]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            seg_ready_q  <= 1'b1;
            beat_digit_q <= 3'd0;
            beat_pat_q   <= 7'd0;
            card_valid_q <= 1'b0;
            card_err_q   <= 1'b0;
            card_slot_q  <= 3'd0;
            card_value_q <= 4'd0;
            player_q     <= 4'd0;
            dealer_q     <= 4'd0;
            // NOTE: the slot and candidate arrays are tiny register files, so they are reset like any flop.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cand_pat_q[i] <= 7'd0;
                cand_cnt_q[i] <= 3'd0;
                slot_q[i]     <= 4'd0;
            end
        end else begin
            card_valid_q <= 1'b0;
            card_err_q   <= 1'b0;
            if (clr) begin
                state_q     <= IDLE;
                seg_ready_q <= 1'b1;
                player_q    <= 4'd0;
                dealer_q    <= 4'd0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    cand_pat_q[i] <= 7'd0;
                    cand_cnt_q[i] <= 3'd0;
                    slot_q[i]     <= 4'd0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (seg_valid && seg_ready_q) begin
                            beat_digit_q <= seg_digit;
                            beat_pat_q   <= seg_pattern;
                            state_q      <= DECODE;
                            seg_ready_q  <= 1'b0;
                        end
                    end
                    DECODE: begin
                        state_q <= SCORE;
                        if (!beat_ok) begin
                            card_err_q <= 1'b1;
                            if (slot_ok) begin
                                cand_cnt_q[slot_idx] <= 3'd0;
                            end
                        end else begin
                            cand_pat_q[slot_idx] <= beat_pat_q;
                            cand_cnt_q[slot_idx] <= cnt_next;
                            if (commit) begin
                                slot_q[slot_idx] <= dec.value;
                            end
                            if (value_changed) begin
                                card_valid_q <= 1'b1;
                                card_slot_q  <= beat_digit_q;
                                card_value_q <= dec.value;
                            end
                        end
                    end
                    SCORE: begin
                        player_q    <= mod10(player_sum);
                        dealer_q    <= mod10(dealer_sum);
                        state_q     <= IDLE;
                        seg_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= IDLE;
                        seg_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Counts the same event that raises card_err; clr leaves it alone.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            err_cnt_q <= 8'd0;
        end else if (!clr && state_q == DECODE && !beat_ok && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

    assign seg_ready    = seg_ready_q;
    assign card_valid   = card_valid_q;
    assign card_err     = card_err_q;
    assign card_slot    = card_slot_q;
    assign card_value   = card_value_q;
    assign player_score = player_q;
    assign dealer_score = dealer_q;

endmodule

// File: tb/tb_seg7_card_decoder.sv
// Directed, table-driven bench for seg7_card_decoder (STABLE_N = 2), plus clr, throughput and async-reset sequences.
module tb_seg7_card_decoder;

    logic       slow_clock;
    logic       resetb;
    logic       clr;
    logic       seg_valid;
    logic       seg_ready;
    logic [2:0] seg_digit;
    logic [6:0] seg_pattern;
    logic       card_valid;
    logic [2:0] card_slot;
    logic [3:0] card_value;
    logic       card_err;
    logic [3:0] player_score;
    logic [3:0] dealer_score;
    logic [7:0] err_count;

`ifdef SEG7_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    seg7_card_decoder #(.STABLE_N(2)) dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .clr         (clr),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_digit   (seg_digit),
        .seg_pattern (seg_pattern),
        .card_valid  (card_valid),
        .card_slot   (card_slot),
        .card_value  (card_value),
        .card_err    (card_err),
        .player_score(player_score),
        .dealer_score(dealer_score),
        .err_count   (err_count)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    typedef struct {
        logic [2:0] d;
        logic [6:0] p;
        logic       v;
        logic       e;
        logic [2:0] s;
        logic [3:0] val;
        logic [3:0] ps;
        logic [3:0] ds;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_errs = 0;

    logic       o_ready_dec, o_valid, o_err, o_valid_after, o_err_after;
    logic [2:0] o_slot;
    logic [3:0] o_val, o_ps, o_ds;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Offers one beat from a negedge and returns at the negedge after the SCORE edge.
    task automatic run_beat(input logic [2:0] d, input logic [6:0] p);
        int waited = 0;
        while (!seg_ready && waited < 10) begin
            @(negedge slow_clock);
            waited++;
        end
        check("ready_wait_timeout", int'(waited >= 10), 0);
        seg_valid   = 1'b1;
        seg_digit   = d;
        seg_pattern = p;
        @(posedge slow_clock);
        @(negedge slow_clock);
        seg_valid   = 1'b0;
        o_ready_dec = seg_ready;
        @(posedge slow_clock);
        @(negedge slow_clock);
        o_valid = card_valid;
        o_err   = card_err;
        o_slot  = card_slot;
        o_val   = card_value;
        @(posedge slow_clock);
        @(negedge slow_clock);
        o_ps          = player_score;
        o_ds          = dealer_score;
        o_valid_after = card_valid;
        o_err_after   = card_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ready_hi;

        //            digit  pattern      v     e     slot  val    ps     ds
        vq.push_back('{3'd0, 7'b0011001, 1'b0, 1'b0, 3'd0, 4'd0,  4'd0, 4'd0});
        vq.push_back('{3'd0, 7'b0011001, 1'b1, 1'b0, 3'd0, 4'd4,  4'd4, 4'd0});
        vq.push_back('{3'd2, 7'b0000000, 1'b0, 1'b0, 3'd0, 4'd4,  4'd4, 4'd0});
        vq.push_back('{3'd2, 7'b0010000, 1'b0, 1'b0, 3'd0, 4'd4,  4'd4, 4'd0});
        vq.push_back('{3'd2, 7'b0010000, 1'b1, 1'b0, 3'd2, 4'd9,  4'd3, 4'd0});
        vq.push_back('{3'd1, 7'b1010101, 1'b0, 1'b1, 3'd2, 4'd9,  4'd3, 4'd0});
        vq.push_back('{3'd7, 7'b0000000, 1'b0, 1'b1, 3'd2, 4'd9,  4'd3, 4'd0});
        vq.push_back('{3'd0, 7'b0010000, 1'b0, 1'b0, 3'd2, 4'd9,  4'd3, 4'd0});
        vq.push_back('{3'd0, 7'b0010000, 1'b1, 1'b0, 3'd0, 4'd9,  4'd8, 4'd0});
        vq.push_back('{3'd1, 7'b0000000, 1'b0, 1'b0, 3'd0, 4'd9,  4'd8, 4'd0});
        vq.push_back('{3'd1, 7'b0000000, 1'b1, 1'b0, 3'd1, 4'd8,  4'd6, 4'd0});
        vq.push_back('{3'd2, 7'b0001001, 1'b0, 1'b0, 3'd1, 4'd8,  4'd6, 4'd0});
        vq.push_back('{3'd2, 7'b0001001, 1'b1, 1'b0, 3'd2, 4'd13, 4'd7, 4'd0});
        vq.push_back('{3'd3, 7'b1000000, 1'b0, 1'b0, 3'd2, 4'd13, 4'd7, 4'd0});
        vq.push_back('{3'd3, 7'b1000000, 1'b1, 1'b0, 3'd3, 4'd10, 4'd7, 4'd0});
        vq.push_back('{3'd4, 7'b1100001, 1'b0, 1'b0, 3'd3, 4'd10, 4'd7, 4'd0});
        vq.push_back('{3'd4, 7'b1100001, 1'b1, 1'b0, 3'd4, 4'd11, 4'd7, 4'd0});
        vq.push_back('{3'd5, 7'b0010010, 1'b0, 1'b0, 3'd4, 4'd11, 4'd7, 4'd0});
        vq.push_back('{3'd5, 7'b0010010, 1'b1, 1'b0, 3'd5, 4'd5,  4'd7, 4'd5});
        vq.push_back('{3'd4, 7'b0000010, 1'b0, 1'b0, 3'd5, 4'd5,  4'd7, 4'd5});
        vq.push_back('{3'd4, 7'b0000010, 1'b1, 1'b0, 3'd4, 4'd6,  4'd7, 4'd1});
        vq.push_back('{3'd4, 7'b0000010, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 4'd1});
        vq.push_back('{3'd3, 7'b0000010, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 4'd1});
        vq.push_back('{3'd5, 7'b0010010, 1'b0, 1'b0, 3'd4, 4'd6,  4'd7, 4'd1});
        vq.push_back('{3'd3, 7'b0000010, 1'b1, 1'b0, 3'd3, 4'd6,  4'd7, 4'd7});
        vq.push_back('{3'd1, 7'b1111111, 1'b0, 1'b0, 3'd3, 4'd6,  4'd7, 4'd7});
        vq.push_back('{3'd1, 7'b1111111, 1'b1, 1'b0, 3'd1, 4'd0,  4'd9, 4'd7});
        vq.push_back('{3'd6, 7'b0001000, 1'b0, 1'b1, 3'd1, 4'd0,  4'd9, 4'd7});
        vq.push_back('{3'd2, 7'b0010000, 1'b0, 1'b0, 3'd1, 4'd0,  4'd9, 4'd7});
        vq.push_back('{3'd2, 7'b1010101, 1'b0, 1'b1, 3'd1, 4'd0,  4'd9, 4'd7});
        vq.push_back('{3'd2, 7'b0010000, 1'b0, 1'b0, 3'd1, 4'd0,  4'd9, 4'd7});
        vq.push_back('{3'd2, 7'b0010000, 1'b1, 1'b0, 3'd2, 4'd9,  4'd8, 4'd7});

        resetb      = 1'b0;
        clr         = 1'b0;
        seg_valid   = 1'b0;
        seg_digit   = 3'd0;
        seg_pattern = 7'd0;
        repeat (2) @(negedge slow_clock);
        check("rst_seg_ready",  int'(seg_ready),  1);
        check("rst_card_valid", int'(card_valid), 0);
        check("rst_card_err",   int'(card_err),   0);
        check("rst_card_slot",  int'(card_slot),  0);
        check("rst_card_value", int'(card_value), 0);
        check("rst_player",     int'(player_score), 0);
        check("rst_dealer",     int'(dealer_score), 0);
        check("rst_err_count",  int'(err_count),  0);
        resetb = 1'b1;
        @(negedge slow_clock);

        for (int i = 0; i < vq.size(); i++) begin
            run_beat(vq[i].d, vq[i].p);
            if (vq[i].e) exp_errs++;
            check($sformatf("v%0d_ready_in_decode", i), int'(o_ready_dec), 0);
            check($sformatf("v%0d_card_valid", i), int'(o_valid), int'(vq[i].v));
            check($sformatf("v%0d_card_err", i),   int'(o_err),   int'(vq[i].e));
            check($sformatf("v%0d_card_slot", i),  int'(o_slot),  int'(vq[i].s));
            check($sformatf("v%0d_card_value", i), int'(o_val),   int'(vq[i].val));
            check($sformatf("v%0d_player", i),     int'(o_ps),    int'(vq[i].ps));
            check($sformatf("v%0d_dealer", i),     int'(o_ds),    int'(vq[i].ds));
            check($sformatf("v%0d_valid_one_cycle", i), int'(o_valid_after), 0);
            check($sformatf("v%0d_err_one_cycle", i),   int'(o_err_after),   0);
            check($sformatf("v%0d_err_count", i), int'(err_count), ERR_EN ? exp_errs : 0);
        end

        // clr during DECODE of an illegal beat: no pulse, everything cleared, err_count kept.
        seg_valid   = 1'b1;
        seg_digit   = 3'd0;
        seg_pattern = 7'b1010101;
        @(posedge slow_clock);
        @(negedge slow_clock);
        seg_valid = 1'b0;
        clr       = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        clr = 1'b0;
        check("clr_seg_ready",  int'(seg_ready),  1);
        check("clr_card_valid", int'(card_valid), 0);
        check("clr_card_err",   int'(card_err),   0);
        check("clr_player",     int'(player_score), 0);
        check("clr_dealer",     int'(dealer_score), 0);
        check("clr_err_count",  int'(err_count),  ERR_EN ? exp_errs : 0);
        run_beat(3'd5, 7'b0010010);
        check("clr_cand_cleared", int'(o_valid), 0);
        run_beat(3'd5, 7'b0010010);
        check("clr_slot_cleared_valid", int'(o_valid), 1);
        check("clr_slot_cleared_value", int'(o_val),   5);
        check("clr_dealer_after",       int'(o_ds),    5);
        check("clr_player_after",       int'(o_ps),    0);

        // Continuous seg_valid: ready high one cycle in three.
        ready_hi    = 0;
        seg_valid   = 1'b1;
        seg_digit   = 3'd0;
        seg_pattern = 7'b1111111;
        for (int c = 0; c < 9; c++) begin
            if (seg_ready) ready_hi++;
            @(negedge slow_clock);
        end
        seg_valid = 1'b0;
        check("throughput_ready_cycles", ready_hi, 3);
        repeat (3) @(negedge slow_clock);
        check("throughput_no_pulse_dealer", int'(dealer_score), 5);

        // resetb pulsed mid-DECODE clears outputs without waiting for a clock edge.
        seg_valid   = 1'b1;
        seg_digit   = 3'd5;
        seg_pattern = 7'b0010010;
        @(posedge slow_clock);
        #2;
        seg_valid = 1'b0;
        resetb    = 1'b0;
        #1;
        check("arst_seg_ready",  int'(seg_ready),  1);
        check("arst_card_valid", int'(card_valid), 0);
        check("arst_card_err",   int'(card_err),   0);
        check("arst_card_slot",  int'(card_slot),  0);
        check("arst_card_value", int'(card_value), 0);
        check("arst_dealer",     int'(dealer_score), 0);
        check("arst_err_count",  int'(err_count),  0);
        @(negedge slow_clock);
        resetb = 1'b1;
        @(negedge slow_clock);
        run_beat(3'd5, 7'b0010010);
        check("arst_fresh_beat_no_commit", int'(o_valid), 0);
        run_beat(3'd5, 7'b0010010);
        check("arst_second_beat_valid", int'(o_valid), 1);
        check("arst_second_beat_slot",  int'(o_slot),  5);
        check("arst_second_beat_dealer", int'(o_ds),   5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
